// File: rtl/seq_display_pkg.sv
// Shared state encoding, blank code and one-hot test for the sequence display player.
// Pure definitions: no latency, no flow control.
package seq_display_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        READ   = 3'd2,
        SHOW   = 3'd3,
        GAP    = 3'd4,
        FINISH = 3'd5
    } state_t;

    localparam logic [7:0] BLANK_CODE = 8'h00;

    // d & (d-1) clears the lowest set bit, so a one-hot value becomes zero.
    function automatic logic is_onehot(input logic [7:0] d);
        return (d != 8'h00) && ((d & (d - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter that stops at zero; zero is decoded from the registered count.
// Load takes effect on the next edge; no backpressure.
module tick_down_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sequence_display_player.sv
// Plays memory entries 0..last_addr on the display: ON_TICKS shown, OFF_TICKS blank, then done.
// Entry period 2+ON+OFF cycles; start ignored while busy, abort returns to IDLE next edge.
module sequence_display_player
    import seq_display_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int ON_TICKS  = 1000,
    parameter int OFF_TICKS = 500,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        code,
    output logic              busy,
    output logic              done,
    output logic              bad_code
);

    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_TICKS - 1);

    state_t            state;
    logic [ADDR_W-1:0] last_q;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_en;
    logic              cnt_zero;

    // The counter is reloaded as READ exits (show time) and as SHOW expires (gap time).
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = ON_LD;
        if (!abort) begin
            if (state == READ) begin
                cnt_load  = 1'b1;
                cnt_value = ON_LD;
            end else if ((state == SHOW) && cnt_zero) begin
                cnt_load  = 1'b1;
                cnt_value = OFF_LD;
            end
        end
    end

    assign cnt_en = (state == SHOW) || (state == GAP);

    tick_down_counter #(.CNT_W(CNT_W)) u_ticks (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cnt_load),
        .value   (cnt_value),
        .en      (cnt_en),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last_q   <= '0;
            mem_addr <= '0;
            code     <= BLANK_CODE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
                code  <= BLANK_CODE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state    <= ADDR;
                            busy     <= 1'b1;
                            last_q   <= last_addr;
                            mem_addr <= '0;
                            bad_code <= 1'b0;
                        end
                    end
                    ADDR: state <= READ;
                    READ: begin
                        code  <= mem_data;
                        state <= SHOW;
                        if (!is_onehot(mem_data)) begin
                            bad_code <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (cnt_zero) begin
                            code  <= BLANK_CODE;
                            state <= GAP;
                        end
                    end
                    GAP: begin
                        if (cnt_zero) begin
                            // Compare before increment so last_addr = all-ones never wraps.
                            if (mem_addr == last_q) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                mem_addr <= mem_addr + ADDR_W'(1);
                                state    <= ADDR;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequence_display_player.sv
// Bench for sequence_display_player: timeline model compared every cycle plus literal pins.
module tb_sequence_display_player;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = 2 + ON + OFF;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] last_addr = 4'd0;
    logic [3:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] code;
    logic       busy, done, bad_code;

    logic       start2 = 1'b0;
    logic [1:0] last_addr2 = 2'd0;
    logic [1:0] mem_addr2;
    logic [7:0] mem_data2 = 8'h00;
    logic [7:0] code2;
    logic       busy2, done2, bad_code2;

    logic [7:0] mem  [0:15];
    logic [7:0] mem2 [0:3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;

    // Model: position inside the current playback, in cycles since the start edge.
    logic       m_active = 1'b0;
    int         m_t = 0;
    int         m_n = 1;
    logic [3:0] m_addr = 4'd0;
    logic       m_bad = 1'b0;

    logic [7:0] code_log [1:29];
    logic [7:0] seq_exp  [1:28] = '{
        8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};

    sequence_display_player #(.ADDR_W(4), .ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .last_addr(last_addr), .mem_addr(mem_addr), .mem_data(mem_data),
        .code(code), .busy(busy), .done(done), .bad_code(bad_code));

    sequence_display_player #(.ADDR_W(2), .ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(16)) dut2 (
        .clock(clock), .reset_n(reset_n), .start(start2), .abort(1'b0),
        .last_addr(last_addr2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .code(code2), .busy(busy2), .done(done2), .bad_code(bad_code2));

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
        mem_data  <= mem[mem_addr];
        mem_data2 <= mem2[mem_addr2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_t      = 0;
            m_addr   = 4'd0;
            m_bad    = 1'b0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t > 1 + m_n * P) begin
                    m_active = 1'b0;
                end else begin
                    if ((m_t - 1) / P < m_n) begin
                        m_addr = 4'((m_t - 1) / P);
                        if (((m_t - 1) % P == 2) && ($countones(mem[(m_t - 1) / P]) != 1))
                            m_bad = 1'b1;
                    end
                end
            end
        end else if (start && !abort) begin
            m_active = 1'b1;
            m_t      = 1;
            m_n      = int'(last_addr) + 1;
            m_addr   = 4'd0;
            m_bad    = 1'b0;
        end
    end

    always @(negedge clock) begin
        int e, o;
        logic [7:0] ec;
        logic eb, ed;
        ec = 8'h00; eb = 1'b0; ed = 1'b0;
        if (m_active) begin
            e  = (m_t - 1) / P;
            o  = (m_t - 1) % P;
            eb = 1'b1;
            ed = (m_t == 1 + m_n * P);
            if (!ed && o >= 2 && o < 2 + ON) ec = mem[e];
        end
        chk("model_busy", busy, eb);
        chk("model_done", done, ed);
        chk("model_code", code, ec);
        chk("model_mem_addr", mem_addr, m_addr);
        chk("model_bad_code", bad_code, m_bad);
        if (cyc - c0 >= 1 && cyc - c0 <= 29) code_log[cyc - c0] = code;
    end

    // Start at the next edge; optionally re-pulse start at cycle poke; return when done is seen.
    task automatic play(input logic [3:0] la, input int poke, output int dt);
        @(negedge clock);
        last_addr = la;
        start = 1'b1;
        c0 = cyc;
        @(negedge clock);
        start = 1'b0;
        dt = -1;
        for (int i = 0; i < 300; i++) begin
            start = (cyc - c0 == poke);
            if (done) begin
                dt = cyc - c0;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    initial begin
        int dt;
        int done_seen;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
        mem2[0] = 8'h01; mem2[1] = 8'h02; mem2[2] = 8'h04; mem2[3] = 8'h08;

        repeat (2) @(negedge clock);
        chk("reset_code", code, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_mem_addr", mem_addr, 4'd0);
        chk("reset_bad_code", bad_code, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        play(4'd3, 0, dt);
        chk("done_cycle_n4", dt, 29);
        for (int t = 1; t <= 28; t++) chk("code_seq", code_log[t], seq_exp[t]);

        play(4'd0, 0, dt);
        chk("done_cycle_n1", dt, 8);
        play(4'd0, 0, dt);
        chk("done_cycle_restart", dt, 8);

        mem[1] = 8'h03;
        play(4'd3, 0, dt);
        chk("done_cycle_badcode", dt, 29);
        chk("bad_code_sticky", bad_code, 1'b1);
        @(negedge clock);
        chk("bad_code_held_idle", bad_code, 1'b1);
        mem[1] = 8'h02;
        play(4'd0, 0, dt);
        chk("bad_code_cleared", bad_code, 1'b0);

        @(negedge clock);
        last_addr = 4'd3;
        start = 1'b1;
        c0 = cyc;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 50 && (cyc - c0) < 13; i++) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_code", code, 8'h00);
        chk("abort_mem_addr_hold", mem_addr, 4'd1);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clock);
        end
        chk("abort_no_done", done_seen, 0);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 1'b0);
        @(negedge clock);
        chk("start_abort_idle2", busy, 1'b0);

        play(4'd3, 10, dt);
        chk("done_cycle_start_busy", dt, 29);

        @(negedge clock);
        last_addr = 4'd3;
        start = 1'b1;
        c0 = cyc;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 50 && (cyc - c0) < 4; i++) @(negedge clock);
        chk("pre_reset_code", code, 8'h01);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_code", code, 8'h00);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_mem_addr", mem_addr, 4'd0);
        chk("async_reset_done", done, 1'b0);
        chk("async_reset_bad", bad_code, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", busy, 1'b0);
        play(4'd1, 0, dt);
        chk("done_cycle_post_reset", dt, 15);

        @(negedge clock);
        last_addr2 = 2'd3;
        start2 = 1'b1;
        c0 = cyc;
        @(negedge clock);
        start2 = 1'b0;
        dt = -1;
        for (int i = 0; i < 300; i++) begin
            if (done2) begin
                dt = cyc - c0;
                break;
            end
            @(negedge clock);
        end
        chk("aw2_done_cycle", dt, 29);
        chk("aw2_mem_addr_done", mem_addr2, 2'd3);
        @(negedge clock);
        chk("aw2_busy_fall", busy2, 1'b0);
        chk("aw2_mem_addr_final", mem_addr2, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
